// File: rtl/free_slot_allocator.sv
// Free-slot bitmap allocator: up to NUM_PORTS same-cycle grants of the lowest free slots,
// bulk release by mask, flush-to-all-free, and a sticky double-free flag.
module free_slot_allocator #(
  parameter int WIDTH       = 64,
  parameter int INDEX_WIDTH = $clog2(WIDTH),
  parameter int NUM_PORTS   = 3
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             flush,
  input  logic [NUM_PORTS-1:0]             alloc_req,
  output logic [NUM_PORTS-1:0]             alloc_grant,
  output logic [NUM_PORTS*INDEX_WIDTH-1:0] alloc_index,
  input  logic [WIDTH-1:0]                 release_mask,
  output logic [WIDTH-1:0]                 free_mask,
  output logic [INDEX_WIDTH:0]             free_count,
  output logic                             double_free_err
);

  localparam int CW = INDEX_WIDTH + 1;

  logic [WIDTH-1:0] avail;
  logic [WIDTH-1:0] granted_onehots;
  logic             found;
  logic [WIDTH-1:0] free_mask_next;
  logic [CW-1:0]    free_count_next;
  logic             double_free_next;

  // Each requester in port order strips the lowest remaining free bit; once the
  // pool is empty every later requester finds nothing, so grants form a prefix.
  always_comb begin
    alloc_grant     = '0;
    alloc_index     = '0;
    granted_onehots = '0;
    avail           = free_mask;
    found           = 1'b0;
    if (!reset && !flush) begin
      for (int unsigned p = 0; p < NUM_PORTS; p++) begin
        found = 1'b0;
        if (alloc_req[p]) begin
          for (int unsigned i = 0; i < WIDTH; i++) begin
            if (!found && avail[i]) begin
              found                                  = 1'b1;
              alloc_grant[p]                         = 1'b1;
              alloc_index[p*INDEX_WIDTH +: INDEX_WIDTH] = INDEX_WIDTH'(i);
              granted_onehots[i]                     = 1'b1;
              avail[i]                               = 1'b0;
            end
          end
        end
      end
    end
  end

  always_comb begin
    free_mask_next   = (free_mask & ~granted_onehots) | release_mask;
    double_free_next = double_free_err | (|(release_mask & free_mask));
    free_count_next  = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      free_count_next = free_count_next + CW'(free_mask_next[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      free_mask       <= '1;
      free_count      <= CW'(WIDTH);
      double_free_err <= 1'b0;
    end else if (flush) begin
      free_mask       <= '1;
      free_count      <= CW'(WIDTH);
    end else begin
      free_mask       <= free_mask_next;
      free_count      <= free_count_next;
      double_free_err <= double_free_next;
    end
  end

endmodule

// File: tb/tb_free_slot_allocator.sv
// Randomized + directed bench for free_slot_allocator; stimulus pushes expectations
// into a queue that a negedge monitor drains and compares.
module tb_free_slot_allocator;

  localparam int W  = 64;
  localparam int NP = 3;
  localparam int IW = 6;

  logic              clk = 1'b0;
  logic              reset, flush;
  logic [NP-1:0]     alloc_req;
  logic [NP-1:0]     alloc_grant;
  logic [NP*IW-1:0]  alloc_index;
  logic [W-1:0]      release_mask;
  logic [W-1:0]      free_mask;
  logic [IW:0]       free_count;
  logic              double_free_err;

  free_slot_allocator #(.WIDTH(W), .INDEX_WIDTH(IW), .NUM_PORTS(NP)) dut (
    .clk(clk), .reset(reset), .flush(flush), .alloc_req(alloc_req),
    .alloc_grant(alloc_grant), .alloc_index(alloc_index), .release_mask(release_mask),
    .free_mask(free_mask), .free_count(free_count), .double_free_err(double_free_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NP-1:0]    grant;
    logic [NP*IW-1:0] index;
    logic [W-1:0]     mask;
    logic [IW:0]      count;
    logic             err;
  } exp_t;

  exp_t       exp_q[$];
  int         total = 0;
  int         bad   = 0;
  bit [W-1:0] mdl_free;
  bit         mdl_err;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: the j-th requester takes the j-th entry of the ascending free-slot list.
  task automatic cycle(input bit rst, input bit fl, input bit [NP-1:0] req, input bit [W-1:0] rel);
    exp_t e;
    int   free_list[$];
    int   j;
    int   cnt;
    reset = rst; flush = fl; alloc_req = req; release_mask = rel;
    cnt = 0;
    for (int i = 0; i < W; i++) if (mdl_free[i]) cnt++;
    e.mask = mdl_free; e.count = (IW+1)'(cnt); e.err = mdl_err;
    e.grant = '0; e.index = '0;
    if (!rst && !fl) begin
      for (int i = 0; i < W; i++) if (mdl_free[i]) free_list.push_back(i);
      j = 0;
      for (int p = 0; p < NP; p++) begin
        if (req[p] && j < free_list.size()) begin
          e.grant[p] = 1'b1;
          e.index[p*IW +: IW] = IW'(free_list[j]);
          j++;
        end else if (req[p]) begin
          j = W + 1;
        end
      end
    end
    exp_q.push_back(e);
    if (rst) begin
      mdl_free = '1; mdl_err = 1'b0;
    end else if (fl) begin
      mdl_free = '1;
    end else begin
      if ((rel & mdl_free) != 0) mdl_err = 1'b1;
      for (int p = 0; p < NP; p++) if (e.grant[p]) mdl_free[e.index[p*IW +: IW]] = 1'b0;
      mdl_free = mdl_free | rel;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        chk("grant", W'(alloc_grant), W'(e.grant));
        chk("index", W'(alloc_index), W'(e.index));
        chk("free_mask", free_mask, e.mask);
        chk("free_count", W'(free_count), W'(e.count));
        chk("double_free_err", W'(double_free_err), W'(e.err));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    bit [W-1:0] rel;
    bit [W-1:0] b63;
    reset = 1'b1; flush = 1'b0; alloc_req = '0; release_mask = '0;
    mdl_free = '1; mdl_err = 1'b0;
    @(posedge clk); #1;

    // Scenario 1 (reset cycle also requests, must not grant)
    cycle(1, 0, 3'b111, '0);
    cycle(0, 0, 3'b111, '0);
    chk("s1_mask_low", W'(free_mask[2:0]), W'(3'b000));
    chk("s1_count", W'(free_count), 64'd61);

    // Scenario 2
    cycle(1, 0, 3'b000, '0);
    cycle(0, 0, 3'b101, '0);
    chk("s2_count", W'(free_count), 64'd62);

    // Scenario 3: drain pool, free only slots 5 and 63
    cycle(1, 0, 3'b000, '0);
    for (int k = 0; k < 22; k++) cycle(0, 0, 3'b111, '0);
    chk("s3_empty", W'(free_count), 64'd0);
    b63 = 64'd1 << 63;
    cycle(0, 0, 3'b000, b63 | (64'd1 << 5));
    chk("s3_two_free", W'(free_count), 64'd2);
    cycle(0, 0, 3'b111, '0);
    chk("s3_count_zero", W'(free_count), 64'd0);
    cycle(0, 0, 3'b111, '0);

    // Scenario 4
    cycle(1, 0, 3'b000, '0);
    cycle(0, 0, 3'b111, '0);
    cycle(0, 0, 3'b001, 64'd1);
    chk("s4_mask_low", W'(free_mask[3:0]), W'(4'b0001));

    // Scenario 5: sticky through flush, cleared by reset
    cycle(1, 0, 3'b000, '0);
    cycle(0, 0, 3'b000, 64'd1 << 10);
    chk("s5_err_set", W'(double_free_err), 64'd1);
    cycle(0, 1, 3'b000, '0);
    chk("s5_err_after_flush", W'(double_free_err), 64'd1);
    cycle(1, 0, 3'b000, '0);
    chk("s5_err_reset", W'(double_free_err), 64'd0);

    // Scenario 6
    cycle(0, 0, 3'b111, '0);
    cycle(0, 1, 3'b111, 64'h0000_0000_0000_00f0);
    chk("s6_mask", free_mask, '1);
    chk("s6_count", W'(free_count), 64'd64);

    // Random traffic
    for (int k = 0; k < 1500; k++) begin
      rel = ~mdl_free & {$urandom, $urandom} & {$urandom, $urandom};
      if ($urandom_range(0, 63) == 0) rel[$urandom_range(0, W-1)] = 1'b1;
      cycle($urandom_range(0, 199) == 0, $urandom_range(0, 49) == 0,
            NP'($urandom_range(0, 7)), rel);
    end

    reset = 1'b1; flush = 1'b0; alloc_req = '0; release_mask = '0;
    for (int k = 0; k < 5 && exp_q.size() > 0; k++) @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/free_slot_allocator.md
FREE_SLOT_ALLOCATOR -- requirements
Module: free_slot_allocator

Interface
REQ-001 Parameter WIDTH, 64, number of tracked slots; legal range 4..128.
REQ-002 Parameter INDEX_WIDTH, $clog2(WIDTH), slot index width.
REQ-003 Parameter NUM_PORTS, 3, allocation ports; legal range 1..4.
REQ-004 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 Port reset  input  1  synchronous, active-high reset.
REQ-006 Port flush  input  1  return every slot to the free pool.
REQ-007 Port alloc_req  input  NUM_PORTS  per-port allocation request; port 0 is oldest.
REQ-008 Port alloc_grant  output  NUM_PORTS  per-port grant, combinational, same cycle.
REQ-009 Port alloc_index  output  NUM_PORTS*INDEX_WIDTH  granted slot per port; port p occupies bits [p*INDEX_WIDTH +: INDEX_WIDTH].
REQ-010 Port release_mask  input  WIDTH  one bit per slot being returned this cycle.
REQ-011 Port free_mask  output  WIDTH  registered bitmap; 1 means the slot is free.
REQ-012 Port free_count  output  INDEX_WIDTH+1  registered popcount of free_mask.
REQ-013 Port double_free_err  output  1  sticky; a release hit an already-free slot.

Function
REQ-014 State: free_mask register, free_count register, double_free_err register; no other state.
REQ-015 Grant rule: requesting ports taken in ascending port order; the j-th requester (j = 0, 1, ...) is granted the j-th lowest-numbered free slot of the current free_mask, if that slot exists.
REQ-016 Grants form a prefix of the requesters: if a requester is denied, every higher-numbered requester is denied in the same cycle.
REQ-017 Non-requesting ports: alloc_grant = 0 and index field = 0; denied ports also drive index 0.
REQ-018 Grants and indices depend only on the registered free_mask, alloc_req and flush; there is no combinational path from release_mask to any grant.
REQ-019 Latency: grant in cycle N; the granted slot is cleared in free_mask and free_count is reduced at the edge ending cycle N, and both are visible in cycle N+1.
REQ-020 Release: every slot with release_mask bit set becomes free at the end of cycle N; it cannot be granted before cycle N+1.
REQ-021 Update equation (no flush): free_mask_next = (free_mask & ~granted_onehots) | release_mask.
REQ-022 free_count_next = popcount(free_mask_next); it must never exceed WIDTH and never wrap.
REQ-023 A release bit on a slot already free in free_mask sets double_free_err at the next edge; the slot stays free. The error is cleared only by reset.
REQ-024 Flush: alloc_grant is all zeros in the flush cycle; at the next edge free_mask becomes all ones and free_count becomes WIDTH; release_mask is ignored; double_free_err is held.
REQ-025 Exhaustion: with free_count = 0, all grants are 0; requesters stall with no error.
REQ-026 Partial availability: with F free slots and R requesters, where F < R, exactly F grants are issued, to the lowest-numbered requesters.
REQ-027 Boundary: slot WIDTH-1 is grantable and releasable like any other slot; indices never exceed WIDTH-1.
REQ-028 Priority at an edge: reset > flush > normal update.

Reset
REQ-029 While reset is high, at each rising edge: free_mask = all ones, free_count = WIDTH, double_free_err = 0.
REQ-030 While reset is high, alloc_grant is all zeros regardless of alloc_req.
REQ-031 Reset asserted mid-operation discards all outstanding allocations; no release is needed afterwards.

Verification (WIDTH=64, NUM_PORTS=3)
REQ-032 Scenario 1: after reset, alloc_req=3'b111 for one cycle. Required: grants 111; indices 0, 1, 2; next cycle free_mask[2:0]=000 and free_count=61.
REQ-033 Scenario 2: alloc_req=3'b101 from reset. Required: port0 gets slot 0, port1 no grant (index 0), port2 gets slot 1; free_count=62 next cycle.
REQ-034 Scenario 3: free_mask has only bits 5 and 63 set, alloc_req=111. Required: grants 011, indices 5 and 63; next cycle free_count=0, and a further request yields grants 000.
REQ-035 Scenario 4: slots 0..2 allocated; same cycle release_mask bit 0 and alloc_req=001. Required: port0 gets slot 3, not slot 0; next cycle free_mask[3:0]=0001.
REQ-036 Scenario 5: release_mask bit 10 while slot 10 is free. Required: double_free_err=1 next cycle, staying 1 through a flush; cleared only by reset.
REQ-037 Scenario 6: flush with alloc_req=111 and release_mask nonzero. Required: grants 000 in that cycle; next cycle free_mask all ones and free_count=64.
